// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver: shadowed display data, per-digit blank/blink,
// leading-zero suppression, PWM brightness and a frame-done strobe.
module seg_scan_driver #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 5000,
    parameter int PWM_BITS     = 3,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  lz_suppress,
    input  logic [PWM_BITS-1:0]   brightness,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg,
    output logic                  frame_done
);

    localparam int TW     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW     = $clog2(DIGITS);
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    // (b_q+1) needs PWM_BITS+1 bits; the product with SCAN_DIV then cannot overflow
    localparam int PROD_W = PWM_BITS + 1 + $clog2(SCAN_DIV + 1);

    localparam logic [TW-1:0]     TICK_LAST  = TW'(SCAN_DIV - 1);
    localparam logic [SW-1:0]     SEL_LAST   = SW'(DIGITS - 1);
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_FRAMES - 1);
    localparam logic [PROD_W-1:0] SCAN_DIV_W = PROD_W'(SCAN_DIV);

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] value_r;
    logic [DIGITS-1:0]   dp_r;
    logic [DIGITS-1:0]   digit_en_r;
    logic [DIGITS-1:0]   blink_mask_r;
    logic                lz_r;

    logic [TW-1:0]       tick_r;
    logic [SW-1:0]       sel_r;
    logic [BW-1:0]       blink_cnt_r;
    logic                blink_phase_r;
    logic [PWM_BITS-1:0] b_q_r;

    logic [DIGITS-1:0]   an_r;
    logic [7:0]          seg_r;
    logic                frame_done_r;

    logic                tick_wrap_s;
    logic                frame_wrap_s;
    logic [PROD_W-1:0]   product_s;
    logic [PROD_W-1:0]   threshold_s;
    logic                pwm_on_s;
    logic                upper_nz_s;
    logic                dark_s;
    logic                supp_s;
    logic [3:0]          nibble_s;
    logic [DIGITS-1:0]   an_s;
    logic [7:0]          seg_s;

    assign tick_wrap_s  = (tick_r == TICK_LAST);
    assign frame_wrap_s = tick_wrap_s && (sel_r == SEL_LAST);

    // Shadow capture of display data so the scan never shows a half-updated value.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            value_r      <= '0;
            dp_r         <= '0;
            digit_en_r   <= '0;
            blink_mask_r <= '0;
            lz_r         <= 1'b0;
        end else if (load) begin
            value_r      <= value;
            dp_r         <= dp;
            digit_en_r   <= digit_en;
            blink_mask_r <= blink_mask;
            lz_r         <= lz_suppress;
        end else begin
            value_r      <= value_r;
            dp_r         <= dp_r;
            digit_en_r   <= digit_en_r;
            blink_mask_r <= blink_mask_r;
            lz_r         <= lz_r;
        end
    end

    // Slot tick, digit select and blink frame counters; free-running regardless of en.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            tick_r        <= '0;
            sel_r         <= '0;
            blink_cnt_r   <= '0;
            blink_phase_r <= 1'b0;
        end else begin
            if (tick_wrap_s) begin
                tick_r <= '0;
                if (sel_r == SEL_LAST) begin
                    sel_r <= '0;
                end else begin
                    sel_r <= sel_r + SW'(1);
                end
            end else begin
                tick_r <= tick_r + TW'(1);
            end
            if (frame_wrap_s) begin
                if (blink_cnt_r == BLINK_LAST) begin
                    blink_cnt_r   <= '0;
                    blink_phase_r <= ~blink_phase_r;
                end else begin
                    blink_cnt_r <= blink_cnt_r + BW'(1);
                end
            end
        end
    end

    // Brightness is held for a whole slot so the duty cycle never changes mid-slot.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            b_q_r <= '0;
        end else if (tick_r == '0) begin
            b_q_r <= brightness;
        end else begin
            b_q_r <= b_q_r;
        end
    end

    assign product_s   = (PROD_W'(b_q_r) + PROD_W'(1)) * SCAN_DIV_W;
    assign threshold_s = product_s >> PWM_BITS;
    assign pwm_on_s    = (PROD_W'(tick_r) < threshold_s);
    assign nibble_s    = value_r[{sel_r, 2'b00} +: 4];

    // Any non-zero nibble at or above the current digit keeps it from being suppressed.
    always_comb begin
        upper_nz_s = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            upper_nz_s = upper_nz_s | ((i >= int'(sel_r)) && (value_r[4*i +: 4] != 4'h0));
        end
    end

    // Digit state and next anode/segment pattern for the current slot.
    always_comb begin
        an_s   = '1;
        seg_s  = 8'hFF;
        dark_s = !en || !digit_en_r[sel_r] || !pwm_on_s
                 || (blink_mask_r[sel_r] && blink_phase_r);
        supp_s = lz_r && (sel_r != '0) && !upper_nz_s;
        if (dark_s) begin
            an_s  = '1;
            seg_s = 8'hFF;
        end else if (supp_s) begin
            an_s  = ~(DIGITS'(1) << sel_r);
            seg_s = {~dp_r[sel_r], 7'h7F};
        end else begin
            an_s  = ~(DIGITS'(1) << sel_r);
            seg_s = {~dp_r[sel_r], hex7(nibble_s)};
        end
    end

    // Output registers; reset drives the display dark immediately.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            an_r         <= '1;
            seg_r        <= 8'hFF;
            frame_done_r <= 1'b0;
        end else begin
            an_r         <= an_s;
            seg_r        <= seg_s;
            frame_done_r <= frame_wrap_s;
        end
    end

    assign an         = an_r;
    assign seg        = seg_r;
    assign frame_done = frame_done_r;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Parametrised multiplexed 7-segment scan driver; next generation of the team's fixed 8-digit display monitor.
- Adds:
  - digit count as a parameter
  - tear-free shadow registers for display data
  - per-digit blanking and blinking
  - leading-zero suppression
  - PWM brightness control
  - a frame-done strobe
- Sits between the clock/timer/stopwatch datapaths and the board AN/HEX pins.

Parameters:
- DIGITS, 8, number of multiplexed digits (2..16).
- SCAN_DIV, 5000, clock cycles per digit slot (≥ 2^PWM_BITS).
- PWM_BITS, 3, width of the brightness input.
- BLINK_FRAMES, 64, full scan frames per blink half-period (≥ 1).

Ports:
- clock  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  global display enable.
- load  in  1  capture display inputs into shadow registers.
- value  in  4*DIGITS  hex nibble per digit; nibble i = digit i; digit 0 is rightmost.
- dp  in  DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  DIGITS  1 = digit used.
- blink_mask  in  DIGITS  1 = digit blinks.
- lz_suppress  in  1  enable leading-zero suppression.
- brightness  in  PWM_BITS  0 = dimmest, all-ones = full.
- an  out  DIGITS  digit anodes, active-low, one-hot.
- seg  out  8  active-low; bit7 = dp, bits 6:0 = g..a.
- frame_done  out  1  one-cycle strobe at end of each frame.

Behaviour:

Shadow registers:
- value, dp, digit_en, blink_mask and lz_suppress are captured on any posedge with load=1.
- Reset clears all of them to 0.
- Display logic reads only the shadows.
- A load mid-frame takes effect from the next cycle.

Counters:
- tick counts 0..SCAN_DIV-1 and wraps to 0.
- On the wrap, sel advances 0..DIGITS-1 and wraps to 0.
- frame_done=1, registered, the cycle after tick wraps while sel=DIGITS-1; it is a single-cycle pulse.
- blink_cnt counts frames 0..BLINK_FRAMES-1; on its wrap blink_phase toggles.
- All counters run regardless of en.
- Reset values: tick=0, sel=0, blink_cnt=0, blink_phase=0.

Brightness:
- brightness is sampled into b_q when tick=0.
- pwm_on = tick < (((b_q+1)*SCAN_DIV) >> PWM_BITS).
- The product must be computed at a width that cannot overflow.
- Maximum brightness gives pwm_on for the whole slot.

Digit state for the current sel:
- Dark when any of: en=0; digit_en[sel]=0; pwm_on=0; blink_mask[sel]=1 with blink_phase=1.
- Suppressed when lz_suppress=1, sel≠0, and nibbles sel..DIGITS-1 are all 0.
- Digit 0 is never suppressed.

Outputs:
- Registered; one cycle after the tick/sel state that produces them.
- Dark: an all ones, seg = 8'hFF.
- Otherwise an = ~(1<<sel).
- Lit digit: seg[6:0] = hex decode, seg[7] = ~dp[sel].
- Suppressed digit: seg[6:0] = 7'h7F, seg[7] = ~dp[sel].
- Hex decode (g..a, active-low):
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110

Reset:
- Reset values: an = all ones, seg = 8'hFF, frame_done = 0, b_q = 0.
- Reset asserted mid-scan forces these values immediately (asynchronously).
- Scan restarts at sel=0, tick=0 on the first posedge after release.

Test Plan:

Bench configuration: DIGITS=4, SCAN_DIV=8, PWM_BITS=3, BLINK_FRAMES=2.

1. Load and scan: release reset → an=1111, seg=FF. Load value=16'h12A4, digit_en=1111, dp=0010, brightness=7 → an walks 1110,1101,1011,0111, 8 cycles each. seg sequence: 8'b10011001, 8'b00001000, 8'b10100100, 8'b11111001. frame_done pulses every 32 cycles.
2. Brightness: brightness=3 → threshold = 4; an is low for tick 0..3 and high for tick 4..7 of every slot. brightness=0 → low for 1 cycle per slot.
3. Leading-zero suppression: lz_suppress=1, value=16'h0305 → digit 3 suppressed (an low, seg FF). Digits 2, 1, 0 show 3, 0, 5. value=16'h0000 → digit 0 shows seg 8'b11000000.
4. Blink: blink_mask=0001 → digit 0 lit in frames 0-1, dark (an=1111 during its slot) in frames 2-3; other digits unaffected.
5. Enable/disable: en=0 → an=1111, seg=FF, yet frame_done still pulses every 32 cycles. Load with digit_en=0101 → slots for digits 1 and 3 show an=1111.
6. Mid-scan reset: assert rst in slot 2 → an=1111, seg=FF the same cycle, shadows cleared. After release, sel restarts at 0 and the display stays dark until the next load.
